// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle between CPU pins, the OAM DMA arbiter and the memory/bus decoder.
// Strobes are active low and single-cycle qualified: an access exists in a cycle
// iff rd_n or wr_n is 0 in that cycle (write wins if both are 0); mem_rdata is
// valid in the same cycle as mem_addr/mem_rd_n, and there is no back-pressure.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd_n;
  logic        mem_wr_n;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic        dma_done;

  // master: the arbiter itself; slave: CPU core + memory decoder side
  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd_n, cpu_wr_n, mem_rdata,
    output cpu_rdata, mem_addr, mem_wdata, mem_rd_n, mem_wr_n, dma_active, dma_done
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd_n, cpu_wr_n, mem_rdata,
    input  cpu_rdata, mem_addr, mem_wdata, mem_rd_n, mem_wr_n, dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Shared CPU/memory bus owner running OAM DMA: a write to DMA_REG_ADDR copies
// DMA_LEN bytes from {reg, idx} to FE00h+idx, CPU confined to HRAM meanwhile.
module oam_dma_arbiter #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          START_DELAY  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  oam_dma_arbiter_if.master    bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } state_e;

  localparam logic [7:0]  LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [7:0]  DELAY_INIT = 8'(START_DELAY);
  localparam logic [15:0] OAM_BASE   = 16'hFE00;

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dma_reg_q, dma_reg_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] delay_q, delay_d;
  logic       done_q, done_d;

  logic cpu_wr;
  logic cpu_rd;
  logic is_dma_reg;
  logic is_hram;
  logic hram_hit;
  logic trigger;
  logic reg_read;
  logic dma_busy;
  logic stall;

  // A cycle with both strobes low is a write, so a read needs wr_n high.
  assign cpu_wr     = ~bus.cpu_wr_n;
  assign cpu_rd     = ~bus.cpu_rd_n & bus.cpu_wr_n;
  assign is_dma_reg = (bus.cpu_addr == DMA_REG_ADDR);
  assign is_hram    = (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr <= 16'hFFFE);
  assign hram_hit   = is_hram & (cpu_rd | cpu_wr);
  assign trigger    = cpu_wr & is_dma_reg;
  assign reg_read   = cpu_rd & is_dma_reg;
  assign dma_busy   = (state_q == RD) || (state_q == WR);
  assign stall      = dma_busy & hram_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'h00;
      dma_reg_q <= 8'hFF;
      latch_q   <= 8'h00;
      delay_q   <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dma_reg_q <= dma_reg_d;
      latch_q   <= latch_d;
      delay_q   <= delay_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dma_reg_d = dma_reg_q;
    latch_d   = latch_q;
    delay_d   = delay_q;
    done_d    = 1'b0;

    // A trigger wins over everything, including an in-flight copy.
    if (trigger) begin
      dma_reg_d = bus.cpu_wdata;
      idx_d     = 8'h00;
      delay_d   = DELAY_INIT;
      state_d   = START;
    end else begin
      case (state_q)
        IDLE: ;
        START: begin
          if (delay_q <= 8'd1) begin
            delay_d = 8'h00;
            state_d = RD;
          end else begin
            delay_d = delay_q - 8'd1;
          end
        end
        RD: begin
          if (!stall) begin
            latch_d = bus.mem_rdata;
            state_d = WR;
          end
        end
        WR: begin
          if (!stall) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = 8'h00;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = RD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_rd_n  = ~cpu_rd;
    bus.mem_wr_n  = ~cpu_wr;
    bus.cpu_rdata = bus.mem_rdata;

    if (dma_busy && !hram_hit && !trigger) begin
      bus.cpu_rdata = 8'hFF;
      bus.mem_wdata = latch_q;
      if (state_q == RD) begin
        bus.mem_addr = {dma_reg_q, idx_q};
        bus.mem_rd_n = 1'b0;
        bus.mem_wr_n = 1'b1;
      end else begin
        bus.mem_addr = OAM_BASE + {8'h00, idx_q};
        bus.mem_rd_n = 1'b1;
        bus.mem_wr_n = 1'b0;
      end
    end else if (is_dma_reg && (cpu_rd || cpu_wr)) begin
      // The DMA register lives here, never on the memory bus.
      bus.mem_rd_n = 1'b1;
      bus.mem_wr_n = 1'b1;
    end

    if (reg_read) begin
      bus.cpu_rdata = dma_reg_q;
    end
  end

  assign bus.dma_active = (state_q != IDLE);
  assign bus.dma_done   = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: driver tasks push expected memory writes,
// CPU read data and dma_done cycles into queues; a negedge monitor checks them.
module tb_oam_dma_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  logic       mon_en = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  logic [23:0] cpu_wq[$];
  logic [7:0]  rd_q[$];
  int          done_q[$];

  oam_dma_arbiter_if bus ();

  oam_dma_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void flag_unexp(string name, logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s got=%h exp=none", name, got);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_wr_n == 1'b0) begin
        if (bus.mem_addr >= 16'hFE00 && bus.mem_addr <= 16'hFE9F) begin
          if (exp_q.size() == 0) flag_unexp("dma_wr", {bus.mem_addr, bus.mem_wdata});
          else check("dma_wr", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
        end else begin
          if (cpu_wq.size() == 0) flag_unexp("cpu_wr", {bus.mem_addr, bus.mem_wdata});
          else check("cpu_wr", {bus.mem_addr, bus.mem_wdata}, cpu_wq.pop_front());
        end
      end
      if (bus.cpu_rd_n == 1'b0) begin
        if (rd_q.size() == 0) flag_unexp("cpu_rdata", bus.cpu_rdata);
        else check("cpu_rdata", bus.cpu_rdata, rd_q.pop_front());
      end
      if (bus.dma_done == 1'b1) begin
        if (done_q.size() == 0) flag_unexp("dma_done", cyc);
        else check("dma_done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_rd_n = 1'b1;
    bus.cpu_wr_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] e);
    rd_q.push_back(e);
    bus.cpu_addr = a;
    bus.cpu_rd_n = 1'b0;
    bus.cpu_wr_n = 1'b1;
    tick();
    drive_idle();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_rd_n  = 1'b1;
    bus.cpu_wr_n  = 1'b0;
    tick();
    drive_idle();
  endtask

  // Expected copy of src page with data i^x; returns the trigger cycle.
  task automatic start_dma(input logic [7:0] src, input logic [7:0] x, output int t);
    for (int i = 0; i < 160; i++) exp_q.push_back({16'hFE00 + 16'(i), 8'(i) ^ x});
    t = cyc;
    done_q.push_back(t + 322);
    bus.cpu_addr  = 16'hFF46;
    bus.cpu_wdata = src;
    bus.cpu_rd_n  = 1'b1;
    bus.cpu_wr_n  = 1'b0;
    @(negedge clk);
    check("trig_not_fwd", bus.mem_wr_n, 1'b1);
    tick();
    drive_idle();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((done_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check("drain_dma_wr", exp_q.size(), 0);
    check("drain_done", done_q.size(), 0);
    check("drain_cpu_wr", cpu_wq.size(), 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) begin
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'hA5;
      mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'h3C;
    end
    mem[16'hC000] = 8'h5A;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    drive_idle();

    // 1: reset state and IDLE passthrough
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_state", dbg_state, 2'd0);
    check("rst_active", bus.dma_active, 1'b0);
    check("rst_done", bus.dma_done, 1'b0);
    tick();
    cpu_read(16'hFF46, 8'hFF);
    rd_q.push_back(8'h5A);
    bus.cpu_addr = 16'hC000;
    bus.cpu_rd_n = 1'b0;
    @(negedge clk);
    check("idle_rd_addr", bus.mem_addr, 16'hC000);
    check("idle_rd_n", bus.mem_rd_n, 1'b0);
    check("idle_active", bus.dma_active, 1'b0);
    tick();
    drive_idle();
    cpu_wq.push_back({16'hC200, 8'h77});
    cpu_write(16'hC200, 8'h77);

    // 2+3: full copy from C100h, CPU blocked outside HRAM
    start_dma(8'hC1, 8'hA5, t);
    @(negedge clk);
    check("start_active", bus.dma_active, 1'b1);
    check("start_no_rd", bus.mem_rd_n, 1'b1);
    tick();
    @(negedge clk);
    check("first_rd_addr", bus.mem_addr, 16'hC100);
    check("first_rd_n", bus.mem_rd_n, 1'b0);
    tick();
    rd_q.push_back(8'hFF);
    bus.cpu_addr = 16'hC000;
    bus.cpu_rd_n = 1'b0;
    @(negedge clk);
    check("blocked_rd_addr", bus.mem_addr, 16'hFE00);
    check("blocked_rd_wr_n", bus.mem_wr_n, 1'b0);
    tick();
    drive_idle();
    bus.cpu_addr  = 16'h8000;
    bus.cpu_wdata = 8'h12;
    bus.cpu_wr_n  = 1'b0;
    @(negedge clk);
    check("blocked_wr_addr", bus.mem_addr, 16'hC101);
    tick();
    drive_idle();
    cpu_read(16'hFF46, 8'hC1);
    wait_done();

    // 4: HRAM writes stall the DMA for 3 cycles at byte 10
    start_dma(8'hC1, 8'hA5, t);
    repeat (21) tick();
    done_q[0] = done_q[0] + 3;
    for (int k = 0; k < 3; k++) cpu_wq.push_back({16'hFF90, 8'h3C});
    bus.cpu_addr  = 16'hFF90;
    bus.cpu_wdata = 8'h3C;
    bus.cpu_wr_n  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hram_addr", bus.mem_addr, 16'hFF90);
      check("hram_wr_n", bus.mem_wr_n, 1'b0);
      tick();
    end
    drive_idle();
    @(negedge clk);
    check("resume_addr", bus.mem_addr, 16'hC10A);
    check("resume_rd_n", bus.mem_rd_n, 1'b0);
    wait_done();

    // 5: retrigger at byte 50 restarts from D000h
    start_dma(8'hC1, 8'hA5, t);
    repeat (101) tick();
    exp_q.delete();
    done_q.delete();
    start_dma(8'hD0, 8'h3C, t);
    tick();
    @(negedge clk);
    check("restart_rd_addr", bus.mem_addr, 16'hD000);
    wait_done();
    repeat (20) tick();

    // 6: reset during WR of byte 80
    start_dma(8'hC1, 8'hA5, t);
    repeat (162) tick();
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_wr_addr", bus.mem_addr, 16'hFE50);
    tick();
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    check("abort_state", dbg_state, 2'd0);
    check("abort_active", bus.dma_active, 1'b0);
    check("abort_done", bus.dma_done, 1'b0);
    tick();
    cpu_read(16'hFF46, 8'hFF);
    repeat (340) tick();
    start_dma(8'hC1, 8'hA5, t);
    wait_done();
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
